// File: rtl/core_ram_resp_if.sv
// core_ram_resp_if: request/response bus between a core fetch or load/store port and a RAM responder
// master: drives req/write/wstrb/addr/wdata and receives ready/rvalid/rdata; slave is the mirror image
interface core_ram_resp_if #(parameter int XLEN = 32);
  logic              req;
  logic              write;
  logic [XLEN/8-1:0] wstrb;
  logic [XLEN-1:0]   addr;
  logic [XLEN-1:0]   wdata;
  logic              ready;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;
  modport master (output req, write, wstrb, addr, wdata, input ready, rvalid, rdata);
  modport slave (input req, write, wstrb, addr, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/core_ram_resp.sv
// core_ram_resp: word-organised RAM responder with byte-strobed writes, fixed read latency and wait states
module core_ram_resp #(
  parameter int    XLEN         = 32,
  parameter int    DEPTH_WORDS  = 4096,
  parameter int    READ_LATENCY = 1,
  parameter int    WAIT_CYCLES  = 0,
  parameter string INIT_FILE    = ""
) (
  input logic             clk,
  input logic             rst_b,
  core_ram_resp_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int NB = XLEN / 8;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic [XLEN-1:0]         dat_q [READ_LATENCY];
  logic [XLEN-1:0]         dat_d [READ_LATENCY];
  logic [XLEN-1:0]         ram [DEPTH_WORDS];
  logic [AW-1:0]           idx;
  logic                    acc;
  logic                    unused_addr;
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_lat
    $error("core_ram_resp: READ_LATENCY must be 1..4");
  end
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 7) begin : g_bad_wait
    $error("core_ram_resp: WAIT_CYCLES must be 0..7");
  end
  if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("core_ram_resp: DEPTH_WORDS must be a power of 2");
  end
  assign idx         = bus.addr[AW+1:2];
  assign unused_addr = ^{bus.addr[XLEN-1:AW+2], bus.addr[1:0]};
  assign acc         = bus.req & ready_q & rst_b;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (acc && WAIT_CYCLES > 0) begin
        state_d = WAIT;
        cnt_d   = 3'(WAIT_CYCLES);
      end
    end else begin
      cnt_d   = cnt_q - 3'd1;
      state_d = cnt_q == 3'd1 ? IDLE : WAIT;
    end
    ready_d  = state_d == IDLE;
    vld_d    = '0;
    dat_d    = dat_q;
    vld_d[0] = acc & ~bus.write;
    dat_d[0] = (acc && !bus.write) ? ram[idx] : dat_q[0];
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      vld_q   <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
    end
  end
  always_ff @(posedge clk) begin
    if (acc && bus.write)
      for (int i = 0; i < NB; i++)
        if (bus.wstrb[i]) ram[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
  end
  assign bus.ready  = ready_q;
  assign bus.rvalid = vld_q[READ_LATENCY-1];
  assign bus.rdata  = dat_q[READ_LATENCY-1];
endmodule

// File: tb/tb_core_ram_resp.sv
// tb_core_ram_resp: directed self-checking bench for three core_ram_resp configurations
module tb_core_ram_resp;
  logic clk = 1'b0;
  logic rst_b;
  int   n_cmp = 0;
  int   n_bad = 0;
  core_ram_resp_if #(.XLEN(32)) b0 ();
  core_ram_resp_if #(.XLEN(32)) b1 ();
  core_ram_resp_if #(.XLEN(32)) b2 ();
  core_ram_resp #(.READ_LATENCY(1), .WAIT_CYCLES(0)) d0 (.clk(clk), .rst_b(rst_b), .bus(b0));
  core_ram_resp #(.READ_LATENCY(3), .WAIT_CYCLES(0)) d1 (.clk(clk), .rst_b(rst_b), .bus(b1));
  core_ram_resp #(.READ_LATENCY(4), .WAIT_CYCLES(2)) d2 (.clk(clk), .rst_b(rst_b), .bus(b2));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    int acc_n;
    int rv_n;
    rst_b = 1'b0;
    b0.req = 0; b0.write = 0; b0.wstrb = 0; b0.addr = 0; b0.wdata = 0;
    b1.req = 0; b1.write = 0; b1.wstrb = 0; b1.addr = 0; b1.wdata = 0;
    b2.req = 0; b2.write = 0; b2.wstrb = 0; b2.addr = 0; b2.wdata = 0;
    repeat (3) tick;
    chk("rst_ready", {31'd0, b0.ready}, 32'd0);
    chk("rst_rvalid", {31'd0, b0.rvalid}, 32'd0);
    chk("rst_rdata", b0.rdata, 32'd0);
    chk("rst_ready_w", {31'd0, b2.ready}, 32'd0);
    rst_b = 1'b1;
    tick;
    chk("rel_ready", {31'd0, b0.ready}, 32'd1);
    chk("rel_ready_w", {31'd0, b2.ready}, 32'd1);
    chk("idle_rvalid", {31'd0, b0.rvalid}, 32'd0);
    b0.req = 1; b0.write = 1; b0.addr = 32'h10; b0.wdata = 32'hDEADBEEF; b0.wstrb = 4'hF;
    tick;
    chk("wr_no_rvalid", {31'd0, b0.rvalid}, 32'd0);
    b0.write = 0;
    tick;
    chk("rd1_rvalid", {31'd0, b0.rvalid}, 32'd1);
    chk("rd1_rdata", b0.rdata, 32'hDEADBEEF);
    b0.req = 0;
    tick;
    chk("hold_rvalid", {31'd0, b0.rvalid}, 32'd0);
    chk("hold_rdata", b0.rdata, 32'hDEADBEEF);
    b0.req = 1; b0.write = 1; b0.addr = 32'h20; b0.wdata = 32'h11223344; b0.wstrb = 4'hF;
    tick;
    b0.wdata = 32'hAABBCCDD; b0.wstrb = 4'h5;
    tick;
    b0.wdata = 32'hFFFFFFFF; b0.wstrb = 4'h0;
    tick;
    b0.write = 0;
    tick;
    chk("strb_rvalid", {31'd0, b0.rvalid}, 32'd1);
    chk("strb_rdata", b0.rdata, 32'h11BB33DD);
    b0.addr = 32'h20 + 32'(4 * 4096);
    tick;
    chk("alias_rvalid", {31'd0, b0.rvalid}, 32'd1);
    chk("alias_rdata", b0.rdata, 32'h11BB33DD);
    b0.req = 0;
    for (int i = 0; i < 4; i++) begin
      b1.req = 1; b1.write = 1; b1.wstrb = 4'hF; b1.addr = 32'(4 * i); b1.wdata = 32'(i + 1);
      tick;
    end
    b1.write = 0;
    for (int c = 0; c < 8; c++) begin
      b1.req = c < 4; b1.addr = 32'(4 * c);
      tick;
      chk($sformatf("pipe_rvalid_%0d", c), {31'd0, b1.rvalid}, {31'd0, c + 1 >= 3 && c + 1 <= 6});
      if (c >= 2) chk($sformatf("pipe_rdata_%0d", c), b1.rdata, c >= 5 ? 32'd4 : 32'(c - 1));
    end
    b1.req = 1; b1.write = 0; b1.addr = 32'h0;
    tick;
    b1.write = 1; b1.wdata = 32'h99; b1.wstrb = 4'hF;
    tick;
    b1.req = 0;
    tick;
    chk("rd_before_wr_rvalid", {31'd0, b1.rvalid}, 32'd1);
    chk("rd_before_wr_rdata", b1.rdata, 32'd1);
    b1.req = 1; b1.write = 0;
    tick;
    b1.req = 0;
    tick;
    tick;
    chk("rd_after_wr_rdata", b1.rdata, 32'h99);
    b2.req = 1; b2.write = 1; b2.addr = 32'h40; b2.wdata = 32'hCAFEF00D; b2.wstrb = 4'hF;
    tick;
    chk("wait_ready_1", {31'd0, b2.ready}, 32'd0);
    tick;
    chk("wait_ready_2", {31'd0, b2.ready}, 32'd0);
    b2.req = 0;
    tick;
    chk("wait_ready_back", {31'd0, b2.ready}, 32'd1);
    b2.req = 1; b2.write = 0;
    acc_n = 0;
    rv_n = 0;
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("ws_ready_%0d", c), {31'd0, b2.ready}, {31'd0, c >= 9 || c % 3 == 0});
      chk($sformatf("ws_rvalid_%0d", c), {31'd0, b2.rvalid}, {31'd0, c == 4 || c == 7 || c == 10});
      if (b2.rvalid) begin
        rv_n++;
        chk($sformatf("ws_rdata_%0d", c), b2.rdata, 32'hCAFEF00D);
      end
      if (b2.req && b2.ready) acc_n++;
      tick;
      if (acc_n == 3) b2.req = 0;
    end
    chk("ws_accepts", 32'(acc_n), 32'd3);
    chk("ws_pulses", 32'(rv_n), 32'd3);
    b2.req = 1;
    tick;
    b2.req = 0;
    tick;
    rst_b = 1'b0;
    b0.req = 1; b0.write = 1; b0.addr = 32'h10; b0.wdata = 32'h0; b0.wstrb = 4'hF;
    tick;
    b0.req = 0;
    chk("mid_rst_rvalid", {31'd0, b2.rvalid}, 32'd0);
    chk("mid_rst_ready", {31'd0, b2.ready}, 32'd0);
    chk("mid_rst_rdata0", b0.rdata, 32'd0);
    rst_b = 1'b1;
    tick;
    chk("mid_rel_rvalid", {31'd0, b2.rvalid}, 32'd0);
    chk("mid_rel_ready", {31'd0, b2.ready}, 32'd1);
    b2.req = 1; b2.write = 0; b2.addr = 32'h40;
    b0.req = 1; b0.write = 0; b0.addr = 32'h10;
    for (int k = 1; k <= 4; k++) begin
      tick;
      b2.req = 0;
      b0.req = 0;
      if (k == 1) chk("rst_wr_dropped", b0.rdata, 32'hDEADBEEF);
      chk($sformatf("fresh_rvalid_%0d", k), {31'd0, b2.rvalid}, {31'd0, k == 4});
    end
    chk("fresh_rdata", b2.rdata, 32'hCAFEF00D);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
